// File: rtl/edge_evt_sched.sv
// Multi-channel edge event scheduler: per-channel synchronizer and rising-edge
// detect, saturating pending counters, round-robin serialisation onto one valid/ready port.
//   state | meaning
//   EMPTY | no event presented
//   FULL  | event presented on evt_ch, waiting for evt_ready
module edge_evt_sched #(
  parameter int N     = 4,
  parameter int IDX_W = 2,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [N-1:0]     ain,
  input  logic [N-1:0]     en,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [IDX_W-1:0] evt_ch,
  output logic             pend_any,
  input  logic             ovf_clr,
  output logic [N-1:0]     ovf
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [N-1:0]       d1, d2, d3;
  logic [N-1:0]       edge_det, inc, dec, elig, ovf_set;
  logic [CNT_W-1:0]   cnt_q [N];
  logic [IDX_W-1:0]   last_q, evt_ch_q, winner;
  logic               found, load;
  logic [N-1:0]       ovf_q;

  // Synchronizer keeps running through reset so a steady level is flushed by release.
  always_ff @(posedge Clk) begin
    d1 <= ain;
    d2 <= d1;
    d3 <= d2;
  end

  assign edge_det = d2 & ~d3;
  assign inc      = edge_det & en & {N{~Rst}};

  always_comb begin
    for (int i = 0; i < N; i++) begin
      elig[i]    = (cnt_q[i] != '0) && en[i];
      dec[i]     = load && (winner == IDX_W'(i));
      ovf_set[i] = inc[i] && !dec[i] && (cnt_q[i] == CNT_MAX);
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= N; k++) begin
      if (!found && elig[(int'(last_q) + k) % N]) begin
        found  = 1'b1;
        winner = IDX_W'((int'(last_q) + k) % N);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (found) begin
          load    = 1'b1;
          state_d = FULL;
        end
      end
      FULL: begin
        if (evt_ready) begin
          if (found) load = 1'b1;
          else state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= EMPTY;
      evt_ch_q <= '0;
      last_q   <= IDX_W'(N - 1);
    end else begin
      state_q <= state_d;
      if (load) begin
        evt_ch_q <= winner;
        last_q   <= winner;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (inc[i] && !dec[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + 1'b1;
        else if (dec[i] && !inc[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
      ovf_q <= (ovf_q & ~{N{ovf_clr}}) | ovf_set;
    end
  end

  assign evt_valid = (state_q == FULL);
  assign evt_ch    = evt_ch_q;
  assign pend_any  = |elig;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_edge_evt_sched.sv
// Directed bench for edge_evt_sched: expected channels queued at stimulus time,
// compared against handshakes captured by a monitor.
module tb_edge_evt_sched;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [3:0] ain, en;
  logic       evt_ready, evt_valid, pend_any, ovf_clr;
  logic [1:0] evt_ch;
  logic [3:0] ovf;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic [1:0] obs_q[$];

  edge_evt_sched #(.N(4), .IDX_W(2), .CNT_W(4)) dut (
    .Clk(Clk), .Rst(Rst), .ain(ain), .en(en), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_ch(evt_ch), .pend_any(pend_any),
    .ovf_clr(ovf_clr), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  always @(negedge Clk)
    if (!Rst && evt_valid && evt_ready) obs_q.push_back(evt_ch);

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int ch);
    ain[ch] = 1'b1;
    tick(2);
    ain[ch] = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick(3);
    Rst = 1'b0;
  endtask

  task automatic drain_check(input string tag);
    chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, "_ch"}, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    Rst = 1'b1; ain = '0; en = '1; evt_ready = 1'b0; ovf_clr = 1'b0;
    tick(3);
    Rst = 1'b0;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_ch", 32'(evt_ch), 0);
    chk("rst_pend", 32'(pend_any), 0);
    chk("rst_ovf", 32'(ovf), 0);

    // single pulse latency
    evt_ready = 1'b1;
    ain[2] = 1'b1;
    tick(1);
    chk("sp_t0", 32'(evt_valid), 0);
    tick(1);
    ain[2] = 1'b0;
    chk("sp_t1", 32'(evt_valid), 0);
    tick(1);
    chk("sp_t2", 32'(evt_valid), 0);
    tick(1);
    chk("sp_t3_valid", 32'(evt_valid), 1);
    chk("sp_t3_ch", 32'(evt_ch), 2);
    exp_q.push_back(2'd2);
    tick(1);
    chk("sp_t4_valid", 32'(evt_valid), 0);
    tick(2);
    drain_check("single");

    // round robin
    do_reset();
    evt_ready = 1'b0;
    ain = 4'hF; tick(2); ain = '0; tick(3);
    chk("rr_valid", 32'(evt_valid), 1);
    chk("rr_first", 32'(evt_ch), 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_seq_valid", 32'(evt_valid), 1);
      chk("rr_seq_ch", 32'(evt_ch), 32'(i));
      exp_q.push_back(2'(i));
      tick(1);
    end
    chk("rr_end", 32'(evt_valid), 0);
    tick(2);
    drain_check("rr");

    // backpressure
    do_reset();
    evt_ready = 1'b0;
    repeat (3) pulse(1);
    for (int i = 0; i < 20; i++) begin
      if (i % 5 == 0) begin
        chk("bp_valid", 32'(evt_valid), 1);
        chk("bp_ch", 32'(evt_ch), 1);
      end
      tick(1);
    end
    chk("bp_pend", 32'(pend_any), 1);
    evt_ready = 1'b1;
    repeat (3) exp_q.push_back(2'd1);
    tick(3);
    evt_ready = 1'b0;
    chk("bp_done_valid", 32'(evt_valid), 0);
    chk("bp_done_pend", 32'(pend_any), 0);
    tick(2);
    drain_check("bp");

    // saturation and overflow
    do_reset();
    evt_ready = 1'b0;
    repeat (16) pulse(0);
    chk("sat_no_ovf", 32'(ovf), 0);
    pulse(0);
    chk("sat_ovf", 32'(ovf), 1);
    tick(3);
    chk("sat_ovf_sticky", 32'(ovf), 1);
    ovf_clr = 1'b1; tick(1); ovf_clr = 1'b0;
    chk("sat_ovf_clr", 32'(ovf), 0);
    evt_ready = 1'b1;
    repeat (16) exp_q.push_back(2'd0);
    tick(24);
    chk("sat_drained", 32'(pend_any), 0);
    drain_check("sat");

    // enable mask
    do_reset();
    en = 4'b0111;
    evt_ready = 1'b1;
    repeat (2) pulse(3);
    tick(3);
    chk("en_pend", 32'(pend_any), 0);
    chk("en_valid", 32'(evt_valid), 0);
    en = 4'hF;
    tick(1);
    chk("en_on_pend", 32'(pend_any), 0);
    pulse(3);
    exp_q.push_back(2'd3);
    tick(3);
    drain_check("en");
    // a held count is masked by en, then granted again once enabled
    evt_ready = 1'b0;
    repeat (2) pulse(2);
    chk("hold_pend", 32'(pend_any), 1);
    en = 4'b1011;
    #1;
    chk("hold_masked", 32'(pend_any), 0);
    chk("hold_presented", 32'(evt_valid), 1);
    en = 4'hF;
    #1;
    chk("hold_unmasked", 32'(pend_any), 1);
    evt_ready = 1'b1;
    repeat (2) exp_q.push_back(2'd2);
    tick(5);
    drain_check("hold");

    // reset mid-operation
    do_reset();
    evt_ready = 1'b0;
    ain = 4'hF; tick(2); ain = '0; tick(3);
    chk("mid_valid", 32'(evt_valid), 1);
    chk("mid_pend", 32'(pend_any), 1);
    ain = 4'hF;
    do_reset();
    chk("mid_rst_valid", 32'(evt_valid), 0);
    chk("mid_rst_pend", 32'(pend_any), 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("mid_quiet", 32'(evt_valid), 0);
    end
    ain = '0;
    drain_check("mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
